// File: rtl/time_display_pkg.sv
// Shared types, sizes and the 7-segment decoder for the HH.MM.SS display.
package time_display_pkg;

  localparam int DIGITS    = 6;
  localparam int CONV_ITER = 6;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CONV_H,
    CONV_M,
    CONV_S,
    COMMIT
  } conv_state_t;

  // Active-high a..g pattern, bit0 = a; non-decimal codes stay dark.
  function automatic logic [6:0] seg7(input bcd_t v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_display_bcd_convert.sv
// Sequential binary-to-BCD converter: snapshots hour/min/sec, splits each into
// tens/units by repeated subtraction, then commits all six digits at once.
module bcd_convert
  import time_display_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              hour,
  input  logic [5:0]              min,
  input  logic [5:0]              sec,
  output bcd_t [DIGITS-1:0]       digit,
  output logic                    busy
);

  conv_state_t state, state_nxt;
  logic [16:0] last;
  logic        force_load;
  logic [5:0]  rem_h, rem_m, rem_s;
  bcd_t        tens_h, tens_m, tens_s;
  logic [2:0]  iter;
  logic        iter_done;
  logic        commit_q;

  assign iter_done = (iter == 3'(CONV_ITER - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (force_load || ({hour, min, sec} != last)) state_nxt = LOAD;
      LOAD:    state_nxt = CONV_H;
      CONV_H:  if (iter_done) state_nxt = CONV_M;
      CONV_M:  if (iter_done) state_nxt = CONV_S;
      CONV_S:  if (iter_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digits are written one cycle after COMMIT so a restart LOAD cannot race them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last       <= '0;
      force_load <= 1'b1;
      rem_h      <= '0;
      rem_m      <= '0;
      rem_s      <= '0;
      tens_h     <= '0;
      tens_m     <= '0;
      tens_s     <= '0;
      iter       <= '0;
      commit_q   <= 1'b0;
      digit      <= '0;
    end else begin
      commit_q <= (state == COMMIT);
      if (commit_q)
        digit <= {tens_h, rem_h[3:0], tens_m, rem_m[3:0], tens_s, rem_s[3:0]};
      case (state)
        LOAD: begin
          last       <= {hour, min, sec};
          force_load <= 1'b0;
          rem_h      <= {1'b0, hour};
          rem_m      <= min;
          rem_s      <= sec;
          tens_h     <= '0;
          tens_m     <= '0;
          tens_s     <= '0;
          iter       <= '0;
        end
        CONV_H: begin
          if (rem_h >= 6'd10) begin
            rem_h  <= rem_h - 6'd10;
            tens_h <= tens_h + 4'd1;
          end
          iter <= iter_done ? 3'd0 : iter + 3'd1;
        end
        CONV_M: begin
          if (rem_m >= 6'd10) begin
            rem_m  <= rem_m - 6'd10;
            tens_m <= tens_m + 4'd1;
          end
          iter <= iter_done ? 3'd0 : iter + 3'd1;
        end
        CONV_S: begin
          if (rem_s >= 6'd10) begin
            rem_s  <= rem_s - 6'd10;
            tens_s <= tens_s + 4'd1;
          end
          iter <= iter_done ? 3'd0 : iter + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/time_display.sv
// 6-digit multiplexed 7-segment driver for HH.MM.SS.
// Optional macro TIME_DISPLAY_LZB_EN: blank the hour-tens digit when it is 0.
module time_display
  import time_display_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       dot,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};
  localparam logic [5:0] AN_INV  = {6{ACTIVE_LOW}};

  logic [17:0] sync1, sync2;
  logic [4:0]  hour_s;
  logic [5:0]  min_s, sec_s;
  logic        dot_s;

  bcd_t [DIGITS-1:0] digit;
  logic              conv_busy;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          tick;

  bcd_t       cur;
  logic       show;
  logic [6:0] seg_c;
  logic [5:0] an_c;
  logic       dp_c;

  // Synchronisers are left out of reset so they track the inputs during reset
  // and the forced first conversion sees real data.
  always_ff @(posedge clk) begin
    sync1 <= {hour, min, sec, dot};
    sync2 <= sync1;
  end

  assign {hour_s, min_s, sec_s, dot_s} = sync2;

  bcd_convert u_conv (
    .clk   (clk),
    .reset (reset),
    .hour  (hour_s),
    .min   (min_s),
    .sec   (sec_s),
    .digit (digit),
    .busy  (conv_busy)
  );

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    cur = '0;
    case (idx)
      3'd0:    cur = digit[0];
      3'd1:    cur = digit[1];
      3'd2:    cur = digit[2];
      3'd3:    cur = digit[3];
      3'd4:    cur = digit[4];
      3'd5:    cur = digit[5];
      default: cur = '0;
    endcase
    show = !blank;
`ifdef TIME_DISPLAY_LZB_EN
    if ((idx == 3'd5) && (digit[5] == 4'd0)) show = 1'b0;
`endif
    an_c  = show ? (6'b1 << idx) : 6'b0;
    seg_c = show ? seg7(cur) : 7'b0;
    dp_c  = show && dot_s && ((idx == 3'd2) || (idx == 3'd4));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_INV;
      dp  <= ACTIVE_LOW;
      an  <= AN_INV;
    end else begin
      seg <= seg_c ^ SEG_INV;
      dp  <= dp_c ^ ACTIVE_LOW;
      an  <= an_c ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: conversion latency, scan, dp, blank, restart, reset.
`timescale 1ns/1ps
module tb_time_display;
  import time_display_pkg::*;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] hour = 5'd12;
  logic [5:0] min = 6'd34;
  logic [5:0] sec = 6'd56;
  logic       dot = 1'b0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int tests = 0;
  int fails = 0;
  int cyc;

  time_display #(.CLK_HZ(4), .SCAN_HZ(1), .ACTIVE_LOW(1'b1)) u_dut (
    .clk   (clk),
    .reset (rst),
    .hour  (hour),
    .min   (min),
    .sec   (sec),
    .dot   (dot),
    .blank (blank),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (u_dut.u_conv.state != LOAD && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(u_dut.u_conv.state), 32'(LOAD));
  endtask

  // Expected scan position: the output register shows index floor((k-1)/4) mod 6 after edge k.
  task automatic check_frame(input string tag, input logic [23:0] dg, input logic dt,
                             input logic blk);
    int i;
    logic [3:0] d;
    logic on;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    i  = (cyc >= 1) ? ((cyc - 1) / 4) % 6 : 0;
    d  = dg[i*4 +: 4];
    on = !blk && (cyc >= 1);
`ifdef TIME_DISPLAY_LZB_EN
    if (i == 5 && d == 4'd0) on = 1'b0;
`endif
    e_an  = on ? ~(6'b1 << i) : 6'h3F;
    e_seg = on ? ~SEG_TAB[d] : 7'h7F;
    e_dp  = !(on && dt && (i == 2 || i == 4));
    chk({tag, ".an"}, 32'(an), 32'(e_an));
    chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
    chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
  endtask

  task automatic sweep(input string tag, input logic [23:0] dg, input logic dt, input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      check_frame(tag, dg, dt, 1'b0);
    end
  endtask

  task automatic convert_and_check(input string tag, input logic [23:0] old_dg,
                                   input logic [23:0] new_dg);
    wait_load({tag, ".load"});
    chk({tag, ".busy"}, 32'(u_dut.conv_busy), 32'd1);
    ticks(20);
    chk({tag, ".before"}, 32'(u_dut.digit), 32'(old_dg));
    tick();
    chk({tag, ".after"}, 32'(u_dut.digit), 32'(new_dg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ticks(3);
    chk("rst.an", 32'(an), 32'h3F);
    chk("rst.seg", 32'(seg), 32'h7F);
    chk("rst.dp", 32'(dp), 32'd1);
    chk("rst.digit", 32'(u_dut.digit), 32'd0);
    chk("rst.state", 32'(u_dut.u_conv.state), 32'(IDLE));
    rst = 1'b0;

    // First forced conversion, latency and scan of 12:34:56
    convert_and_check("first", 24'h000000, 24'h123456);
    chk("first.idle", 32'(u_dut.conv_busy), 32'd0);
    tick();
    sweep("scan", 24'h123456, 1'b0, 24);

    // dot lights minute-units and hour-units only
    dot = 1'b1;
    set_time(23, 59, 59);
    convert_and_check("dot", 24'h123456, 24'h235959);
    tick();
    sweep("dot1", 24'h235959, 1'b1, 24);
    dot = 1'b0;
    ticks(3);
    sweep("dot0", 24'h235959, 1'b0, 24);

    // Out-of-range values pass straight through
    set_time(31, 63, 0);
    convert_and_check("oor", 24'h235959, 24'h316300);
    tick();
    sweep("oor", 24'h316300, 1'b0, 12);

    // Input change during CONV_M: no mixed frame, restart after COMMIT
    set_time(23, 59, 58);
    wait_load("mid.load");
    ticks(11);
    sec = 6'd59;
    ticks(9);
    chk("mid.old", 32'(u_dut.digit), 32'h316300);
    tick();
    chk("mid.first", 32'(u_dut.digit), 32'h235958);
    chk("mid.restart", 32'(u_dut.u_conv.state), 32'(LOAD));
    ticks(20);
    chk("mid.hold", 32'(u_dut.digit), 32'h235958);
    tick();
    chk("mid.second", 32'(u_dut.digit), 32'h235959);
    tick();

    // blank for 10 cycles while scanning continues
    sweep("preblank", 24'h235959, 1'b0, 3);
    blank = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      check_frame("blank", 24'h235959, 1'b0, 1'b1);
    end
    blank = 1'b0;
    sweep("unblank", 24'h235959, 1'b0, 8);

    // Hour tens of zero (leading-zero blanking only with the macro)
    set_time(7, 5, 9);
    convert_and_check("lzb", 24'h235959, 24'h070509);
    tick();
    sweep("lzb", 24'h070509, 1'b0, 24);

    // Reset mid-conversion, then forced reconversion
    set_time(12, 34, 56);
    wait_load("rmid.load");
    ticks(8);
    rst = 1'b1;
    #1;
    chk("rmid.state", 32'(u_dut.u_conv.state), 32'(IDLE));
    chk("rmid.digit", 32'(u_dut.digit), 32'd0);
    chk("rmid.an", 32'(an), 32'h3F);
    ticks(2);
    rst = 1'b0;
    convert_and_check("rmid", 24'h000000, 24'h123456);
    tick();
    sweep("rmid", 24'h123456, 1'b0, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
